// File: rtl/cirno9_ifu_if.sv
// cirno9_ifu_if: fetch-unit bus bundle (redirect, memory request/response, decode handoff); master = fetch unit, slave = environment
interface cirno9_ifu_if;
  logic        i_setpc;
  logic [31:0] i_pc;
  logic        hs_if4mem_val;
  logic        hs_mem4if_rdy;
  logic [31:0] o_mem_adr;
  logic        hs_mem4if_rsp;
  logic [31:0] i_mem_rdat;
  logic        i_mem_err;
  logic        hs_if4de_val;
  logic        hs_de4if_rdy;
  logic [31:0] o_in;
  logic [31:0] o_in_pc;
  logic        o_in_err;
  modport master (
    input  i_setpc, i_pc, hs_mem4if_rdy, hs_mem4if_rsp, i_mem_rdat, i_mem_err, hs_de4if_rdy,
    output hs_if4mem_val, o_mem_adr, hs_if4de_val, o_in, o_in_pc, o_in_err
  );
  modport slave (
    output i_setpc, i_pc, hs_mem4if_rdy, hs_mem4if_rsp, i_mem_rdat, i_mem_err, hs_de4if_rdy,
    input  hs_if4mem_val, o_mem_adr, hs_if4de_val, o_in, o_in_pc, o_in_err
  );
endinterface

// File: rtl/cirno9_ifu.sv
// cirno9_ifu: credit-limited instruction fetch unit; ports clk, rst (async, active-high), bus (cirno9_ifu_if.master: redirect, memory request/response, decode queue head)
module cirno9_ifu #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  cirno9_ifu_if.master      bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [CW-1:0] inflight, drop, count, credit;
  logic [PW-1:0] wp, rp;
  logic [31:0]   fpc, rpc, tgt;
  logic [31:0]   q_dat [DEPTH];
  logic [31:0]   q_pc  [DEPTH];
  logic [DEPTH-1:0] q_err;
  logic acc, rsp_ok, dropping, ret, push, pop, sp;
  assign sp       = bus.i_setpc;
  assign tgt      = bus.i_pc & ~32'h3;
  assign credit   = inflight + count + drop;
  assign acc      = bus.hs_if4mem_val && bus.hs_mem4if_rdy;
  // responses with nothing outstanding are strays and leave all state untouched
  assign rsp_ok   = bus.hs_mem4if_rsp && (inflight != '0 || drop != '0);
  // older, flushed requests answer first, so pending drops absorb responses before live ones
  assign dropping = rsp_ok && drop != '0;
  assign ret      = rsp_ok && drop == '0;
  assign push     = ret && !sp;
  assign pop      = bus.hs_if4de_val && bus.hs_de4if_rdy && !sp;
  assign bus.hs_if4mem_val = !rst && credit < CW'(DEPTH) && !sp;
  assign bus.o_mem_adr     = fpc;
  assign bus.hs_if4de_val  = count != '0;
  assign bus.o_in          = bus.hs_if4de_val ? q_dat[rp] : '0;
  assign bus.o_in_pc       = bus.hs_if4de_val ? q_pc[rp]  : '0;
  assign bus.o_in_err      = bus.hs_if4de_val && q_err[rp];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc      <= RESET_PC;
      rpc      <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      wp       <= '0;
      rp       <= '0;
    end else begin
      fpc      <= sp ? tgt : acc ? fpc + 32'd4 : fpc;
      rpc      <= sp ? tgt : push ? rpc + 32'd4 : rpc;
      inflight <= sp ? '0 : inflight + CW'(acc) - CW'(ret);
      // a response landing in the redirect cycle retires one of the requests being flushed
      drop     <= sp ? drop + inflight + CW'(acc) - CW'(rsp_ok) : drop - CW'(dropping);
      count    <= sp ? '0 : count + CW'(push) - CW'(pop);
      wp       <= sp ? '0 : wp + PW'(push);
      rp       <= sp ? '0 : rp + PW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_dat[wp] <= bus.i_mem_rdat;
      q_pc[wp]  <= rpc;
      q_err[wp] <= bus.i_mem_err;
    end
  end
endmodule

// File: doc/cirno9_ifu.md
CIRNO9_IFU -- requirements
Module: cirno9_ifu

Interface
REQ-001 SHALL have parameter DEPTH, default 4; fetch-queue entries, power of two, range 2..16.
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000; first fetch address, word aligned.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_setpc  in  1  redirect (branch/jump/trap) from exu.
REQ-006 SHALL have port i_pc  in  32  redirect target; bits [1:0] ignored.
REQ-007 SHALL have port hs_if4mem_val  out  1  fetch request valid.
REQ-008 SHALL have port hs_mem4if_rdy  in  1  memory accepts request.
REQ-009 SHALL have port o_mem_adr  out  32  fetch address, bits [1:0] always 0.
REQ-010 SHALL have port hs_mem4if_rsp  in  1  response valid; in order, at most one per cycle.
REQ-011 SHALL have port i_mem_rdat  in  32  response instruction word.
REQ-012 SHALL have port i_mem_err  in  1  response bus error.
REQ-013 SHALL have port hs_if4de_val  out  1  instruction valid to decode.
REQ-014 SHALL have port hs_de4if_rdy  in  1  decode consumes instruction.
REQ-015 SHALL have port o_in  out  32  head instruction word.
REQ-016 SHALL have port o_in_pc  out  32  PC of head instruction.
REQ-017 SHALL have port o_in_err  out  1  head entry carries bus error.

Function
REQ-018 SHALL hold fetch PC register fpc; o_mem_adr = fpc; fpc += 4 on each accepted request (val && rdy), wrapping 32'hFFFF_FFFC -> 0.
REQ-019 SHALL keep credit = inflight + queue occupancy + drop count; hs_if4mem_val = (credit < DEPTH) && !i_setpc.
REQ-020 SHALL, once hs_if4mem_val is high, keep it high with o_mem_adr stable until accepted, unless i_setpc.
REQ-021 SHALL push each non-dropped response into the queue as {i_mem_rdat, rpc, i_mem_err}; rpc += 4 per push.
REQ-022 SHALL drive hs_if4de_val = queue not empty; o_in/o_in_pc/o_in_err from head entry, all zero when empty.
REQ-023 SHALL pop head on hs_if4de_val && hs_de4if_rdy; push and pop in same cycle both take effect, occupancy unchanged.
REQ-024 SHALL never overflow queue: credit limit guarantees a slot for every in-flight response.
REQ-025 SHALL, on i_setpc, in that cycle: empty queue, fpc <= {i_pc[31:2],2'b00}, rpc <= same, drop <= drop + inflight (counting a request accepted that cycle), inflight <= 0.
REQ-026 SHALL discard responses while drop > 0, decrementing drop; queue and rpc unchanged.
REQ-027 SHALL give i_setpc priority over same-cycle pop and push: both ignored, data lost by design.
REQ-028 SHALL ignore a response arriving with inflight == 0 and drop == 0: no state change.
REQ-029 SHALL latch i_mem_err entries normally, same queueing and flush treatment; fetching continues.
REQ-030 SHALL give minimum latency response-to-hs_if4de_val of 1 cycle (registered queue, no bypass).
REQ-031 SHALL sustain one request and one instruction per cycle when memory returns responses back-to-back.

Reset
REQ-032 SHALL, while rst high, clear queue, inflight, drop; fpc = rpc = RESET_PC.
REQ-033 SHALL drive hs_if4mem_val = 0, hs_if4de_val = 0, o_in = o_in_pc = 0, o_in_err = 0 and o_mem_adr = RESET_PC during reset.
REQ-034 SHALL assert hs_if4mem_val in the first clock edge cycle after rst deasserts.
REQ-035 SHALL discard any response arriving in the reset cycle or in flight at reset.

Verification
REQ-036 SHALL cover streaming: rdy=1, responses 1 cycle later, de_rdy=1 -> o_in_pc 8000_0000, 8000_0004, ... one per cycle, no bubbles.
REQ-037 SHALL cover backpressure: de_rdy=0, DEPTH=4 -> exactly 4 requests issued, then val=0 until a pop.
REQ-038 SHALL cover flush with 3 in flight: i_setpc, i_pc=32'h0000_1002 -> 3 responses dropped, next o_in_pc = 0000_1000, fpc resumes 0000_1000.
REQ-039 SHALL cover simultaneous i_setpc and pop with full queue -> queue empty next cycle, no pop credited.
REQ-040 SHALL cover error: i_mem_err=1 on second response -> o_in_err=1 only for o_in_pc 8000_0004.
REQ-041 SHALL cover mid-stream reset with 2 in flight -> outputs per REQ-033, late responses ignored, refetch from 8000_0000.
